int_status_controller: RTL and testbench
========================================

// Module: int_status_controller
// PURPOSE
//  Downstream consumer of the interrupt-event FIFO (ControllerFIFO) in the AXI4 DMA controller.
//  - Pops one queued interrupt event at a time and holds it in a status register.
//  - Drives the host interrupt line and waits for a host clear strobe before popping the next event.
//  - Tracks FIFO watermark hits, ECC error flags and a serviced-event count for the register block.
// PARAMETERS
//  FIFO_WIDTH  8   width of one interrupt event word (opaque payload, matches FIFO)
//  CNT_WIDTH   16  width of serviced-event counter (saturating)
// PORTS
//  clock              in   1            system clock; all logic rising-edge
//  reset              in   1            synchronous, active-high reset
//  fifoEmpty          in   1            FIFO empty flag
//  wMarkFull          in   1            FIFO occupancy == watermark
//  fifoRdData         in   FIFO_WIDTH   FIFO read data, valid 1 cycle after fifoRdEn
//  error_flag_sb_fifo in   1            ECC single-bit corrected, qualifies fifoRdData
//  error_flag_db_fifo in   1            ECC double-bit detected, qualifies fifoRdData
//  fifoRdEn           out  1            FIFO pop strobe, 1 cycle per event
//  intEn              in   1            interrupt output enable (mask)
//  intClr             in   1            host clear strobe for current event (1 cycle)
//  errClr             in   1            clears sticky wMark/SB/DB flags
//  intStatus          out  FIFO_WIDTH   captured event word
//  intValid           out  1            intStatus holds an unserviced event
//  irq                out  1            intValid & intEn, registered
//  morePending        out  1            ~fifoEmpty while intValid
//  eventDbErr         out  1            current event captured with DB error
//  wMarkSticky        out  1            wMarkFull seen since last errClr
//  sbErrSticky        out  1            SB correction seen since last errClr
//  dbErrSticky        out  1            DB error seen since last errClr
//  eventCnt           out  CNT_WIDTH    events captured since reset, saturates at all-ones
// BEHAVIOUR
//  Reset: state IDLE; every output 0; counter 0; event register 0.
//  FSM (Moore; fifoRdEn = (state==POP)):
//  - IDLE: go to POP if !fifoEmpty, else stay.
//  - POP: fifoRdEn=1 for exactly one cycle, then go to WAIT.
//  - WAIT: at end of cycle, capture fifoRdData into intStatus; set intValid; capture DB flag into eventDbErr; go to PRESENT.
//  - PRESENT: on intClr, clear intValid and eventDbErr; go to POP if !fifoEmpty, else IDLE.
//  Latency:
//  - fifoEmpty seen low at edge N gives fifoRdEn high in cycle N+1, and intValid/intStatus valid from cycle N+3.
//  - irq follows one cycle later, at N+4.
//  - intClr at edge M with FIFO non-empty gives the next pop in cycle M+1.
//  - Throughput: one event per 3 cycles plus the host clear.
//  Handshake:
//  - intClr outside PRESENT is ignored.
//  - fifoRdEn is never asserted while fifoEmpty=1 at the preceding edge, so the FIFO never underflows.
//  - FIFO occupancy updates the cycle after the pop, before the WAIT-state decision.
//  - intEn=0 masks irq only; the FSM and capture still proceed, and intValid stays visible.
//  Sticky flags:
//  - wMarkSticky, sbErrSticky and dbErrSticky set on their inputs.
//  - SB/DB inputs are sampled in WAIT only; wMarkFull is sampled every cycle.
//  - errClr clears the sticky flags. errClr with a same-cycle set leaves the flag set (set wins).
//  - eventDbErr is per event, distinct from dbErrSticky; a DB event is still presented to the host.
//  eventCnt:
//  - Increments on each WAIT capture.
//  - Holds at 2^CNT_WIDTH-1; no wrap.
//  Reset mid-operation:
//  - Reset in any state returns to IDLE next edge with fifoRdEn=0 and the event dropped.
//  - The top level resets the FIFO together with this block (resetn = ~reset).
// TESTING
//  1. Reset, then write 0xA5 to FIFO -> fifoRdEn pulses once; intStatus=0xA5, intValid=1 two cycles after the pop; irq=1 next cycle with intEn=1.
//  2. Queue 0x11,0x22,0x33; pulse intClr each time irq=1 -> intStatus sequence 11,22,33; morePending 1,1,0; eventCnt=3; FSM ends in IDLE.
//  3. intEn=0 with an event queued -> intValid=1, irq stays 0; raise intEn -> irq=1 next cycle; intClr while IDLE -> no effect.
//  4. Force error_flag_db_fifo=1 during WAIT for event 0x5C -> eventDbErr=1, dbErrSticky=1; intClr clears eventDbErr only; errClr clears sticky.
//  5. Fill FIFO to watermark with no clears -> wMarkSticky=1; assert reset in POP -> outputs 0 next edge, fifoRdEn=0, eventCnt=0.
//  6. CNT_WIDTH=2, service 5 events -> eventCnt saturates at 3.

Source files
------------

// File: rtl/int_status_controller.sv
// Interrupt status controller: pops events from the interrupt FIFO one at a time,
// presents each to the host until cleared, and keeps sticky error/watermark flags.
module int_status_controller #(
    parameter int FIFO_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifoEmpty,
    input  logic                  wMarkFull,
    input  logic [FIFO_WIDTH-1:0] fifoRdData,
    input  logic                  error_flag_sb_fifo,
    input  logic                  error_flag_db_fifo,
    output logic                  fifoRdEn,
    input  logic                  intEn,
    input  logic                  intClr,
    input  logic                  errClr,
    output logic [FIFO_WIDTH-1:0] intStatus,
    output logic                  intValid,
    output logic                  irq,
    output logic                  morePending,
    output logic                  eventDbErr,
    output logic                  wMarkSticky,
    output logic                  sbErrSticky,
    output logic                  dbErrSticky,
    output logic [CNT_WIDTH-1:0]  eventCnt
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] POP     = 2'd1;
    localparam logic [1:0] WAIT    = 2'd2;
    localparam logic [1:0] PRESENT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0] state;
    logic [1:0] state_next;
    logic       capture;
    logic       clear;

    assign capture     = (state == WAIT);
    assign clear       = (state == PRESENT) && intClr;
    assign fifoRdEn    = (state == POP);
    assign morePending = intValid && !fifoEmpty;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!fifoEmpty) state_next = POP;
            POP:     state_next = WAIT;
            WAIT:    state_next = PRESENT;
            PRESENT: if (intClr) state_next = fifoEmpty ? IDLE : POP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Event register: read data is only valid in WAIT, one cycle after the pop strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            intStatus  <= '0;
            intValid   <= 1'b0;
            eventDbErr <= 1'b0;
            irq        <= 1'b0;
        end else begin
            irq <= intValid && intEn;
            if (capture) begin
                intStatus  <= fifoRdData;
                intValid   <= 1'b1;
                eventDbErr <= error_flag_db_fifo;
            end else if (clear) begin
                intValid   <= 1'b0;
                eventDbErr <= 1'b0;
            end
        end
    end

    // Sticky flags: a same-cycle set beats errClr so no event is ever lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            wMarkSticky <= 1'b0;
            sbErrSticky <= 1'b0;
            dbErrSticky <= 1'b0;
        end else begin
            wMarkSticky <= wMarkFull || (wMarkSticky && !errClr);
            sbErrSticky <= (capture && error_flag_sb_fifo) || (sbErrSticky && !errClr);
            dbErrSticky <= (capture && error_flag_db_fifo) || (dbErrSticky && !errClr);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            eventCnt <= '0;
        end else if (capture && (eventCnt != CNT_MAX)) begin
            eventCnt <= eventCnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_int_status_controller.sv
// Bench for int_status_controller: behavioural FIFO model, a cycle-by-cycle vector
// table for basic servicing, and directed sequences for masking, errors, reset and saturation.
module tb_int_status_controller;

    localparam int WMARK = 4;

    logic        clock;
    logic        reset;
    logic        fifoEmpty;
    logic        wMarkFull;
    logic [7:0]  fifoRdData;
    logic        error_flag_sb_fifo;
    logic        error_flag_db_fifo;
    logic        fifoRdEn;
    logic        intEn;
    logic        intClr;
    logic        errClr;
    logic [7:0]  intStatus;
    logic        intValid;
    logic        irq;
    logic        morePending;
    logic        eventDbErr;
    logic        wMarkSticky;
    logic        sbErrSticky;
    logic        dbErrSticky;
    logic [15:0] eventCnt;

    logic        rd_en2;
    logic [7:0]  status2;
    logic        valid2;
    logic        irq2;
    logic        more2;
    logic        db_err2;
    logic        wmark2;
    logic        sb_sticky2;
    logic        db_sticky2;
    logic [1:0]  cnt2;

    logic        push_en;
    logic [9:0]  push_word;
    logic [9:0]  mem [16];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    int          count;
    logic        underflow;

    int compares;
    int fails;

    int_status_controller #(.FIFO_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .fifoEmpty(fifoEmpty), .wMarkFull(wMarkFull),
        .fifoRdData(fifoRdData), .error_flag_sb_fifo(error_flag_sb_fifo),
        .error_flag_db_fifo(error_flag_db_fifo), .fifoRdEn(fifoRdEn), .intEn(intEn),
        .intClr(intClr), .errClr(errClr), .intStatus(intStatus), .intValid(intValid),
        .irq(irq), .morePending(morePending), .eventDbErr(eventDbErr),
        .wMarkSticky(wMarkSticky), .sbErrSticky(sbErrSticky), .dbErrSticky(dbErrSticky),
        .eventCnt(eventCnt)
    );

    // Narrow-counter copy sees identical stimulus; only its counter is checked.
    int_status_controller #(.FIFO_WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clock(clock), .reset(reset), .fifoEmpty(fifoEmpty), .wMarkFull(wMarkFull),
        .fifoRdData(fifoRdData), .error_flag_sb_fifo(error_flag_sb_fifo),
        .error_flag_db_fifo(error_flag_db_fifo), .fifoRdEn(rd_en2), .intEn(intEn),
        .intClr(intClr), .errClr(errClr), .intStatus(status2), .intValid(valid2),
        .irq(irq2), .morePending(more2), .eventDbErr(db_err2),
        .wMarkSticky(wmark2), .sbErrSticky(sb_sticky2), .dbErrSticky(db_sticky2),
        .eventCnt(cnt2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign fifoEmpty = (count == 0);
    assign wMarkFull = (count == WMARK);

    // FIFO model: entries are {db, sb, data}; read data and flags appear the cycle after the pop.
    always @(posedge clock) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= 0;
            fifoRdData         <= '0;
            error_flag_sb_fifo <= 1'b0;
            error_flag_db_fifo <= 1'b0;
            underflow          <= 1'b0;
        end else begin
            if (push_en) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + 4'd1;
            end
            if (fifoRdEn && count == 0) underflow <= 1'b1;
            if (fifoRdEn && count != 0) begin
                {error_flag_db_fifo, error_flag_sb_fifo, fifoRdData} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 4'd1;
            end
            count <= count + (push_en ? 1 : 0) - ((fifoRdEn && count != 0) ? 1 : 0);
        end
    end

    typedef struct packed {
        logic        push;
        logic [7:0]  data;
        logic        clr;
        logic        rd_en;
        logic        valid;
        logic [7:0]  status;
        logic        irq;
        logic        more;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [23];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, take the edge, then settle 1 time unit past it.
    task automatic applyStimulus(input logic push, input logic [7:0] data, input logic db,
                                 input logic sb, input logic clr, input logic eclr);
        push_en   = push;
        push_word = {db, sb, data};
        intClr    = clr;
        errClr    = eclr;
        @(posedge clock);
        #1;
        push_en = 1'b0;
        intClr  = 1'b0;
        errClr  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic serviceEvent(input logic [7:0] data);
        int waited;
        applyStimulus(1'b1, data, 1'b0, 1'b0, 1'b0, 1'b0);
        waited = 0;
        while (!intValid && waited < 20) begin
            idle(1);
            waited++;
        end
        checkOutput("svc_status", {24'd0, intStatus}, {24'd0, data});
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
    endtask

    initial begin
        compares  = 0;
        fails     = 0;
        reset     = 1'b1;
        intEn     = 1'b1;
        intClr    = 1'b0;
        errClr    = 1'b0;
        push_en   = 1'b0;
        push_word = '0;

        //          push data   clr  rd   valid stat   irq  more cnt
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 16'd1};
        vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
        vecs[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
        vecs[8]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
        vecs[9]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 16'd1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 16'd2};
        vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 16'd2};
        vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 16'd2};
        vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 16'd3};
        vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 16'd3};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 16'd3};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 16'd3};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 16'd4};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 16'd4};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 16'd4};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 16'd4};
        vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 16'd4};

        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_rd_en",  {31'd0, fifoRdEn}, 32'd0);
        checkOutput("rst_valid",  {31'd0, intValid}, 32'd0);
        checkOutput("rst_status", {24'd0, intStatus}, 32'd0);
        checkOutput("rst_irq",    {31'd0, irq}, 32'd0);
        checkOutput("rst_cnt",    {16'd0, eventCnt}, 32'd0);
        checkOutput("rst_sticky", {29'd0, wMarkSticky, sbErrSticky, dbErrSticky}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            applyStimulus(vecs[i].push, vecs[i].data, 1'b0, 1'b0, vecs[i].clr, 1'b0);
            checkOutput($sformatf("v%0d_rd_en", i),  {31'd0, fifoRdEn}, {31'd0, vecs[i].rd_en});
            checkOutput($sformatf("v%0d_valid", i),  {31'd0, intValid}, {31'd0, vecs[i].valid});
            checkOutput($sformatf("v%0d_status", i), {24'd0, intStatus}, {24'd0, vecs[i].status});
            checkOutput($sformatf("v%0d_irq", i),    {31'd0, irq}, {31'd0, vecs[i].irq});
            checkOutput($sformatf("v%0d_more", i),   {31'd0, morePending}, {31'd0, vecs[i].more});
            checkOutput($sformatf("v%0d_cnt", i),    {16'd0, eventCnt}, {16'd0, vecs[i].cnt});
        end

        // Masked interrupt, with intClr held while the event is still being fetched.
        intEn = 1'b0;
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mask_pop", {31'd0, fifoRdEn}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        checkOutput("mask_valid",  {31'd0, intValid}, 32'd1);
        checkOutput("mask_status", {24'd0, intStatus}, 32'h77);
        idle(2);
        checkOutput("mask_irq", {31'd0, irq}, 32'd0);
        checkOutput("mask_hold_valid", {31'd0, intValid}, 32'd1);
        intEn = 1'b1;
        idle(1);
        checkOutput("unmask_irq", {31'd0, irq}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mask_clr_valid", {31'd0, intValid}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("idle_clr_rd_en", {31'd0, fifoRdEn}, 32'd0);
        checkOutput("idle_clr_cnt",   {16'd0, eventCnt}, 32'd5);
        idle(1);
        checkOutput("idle_irq", {31'd0, irq}, 32'd0);

        // Double-bit error event: per-event flag versus sticky flag.
        applyStimulus(1'b1, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        checkOutput("db_status",   {24'd0, intStatus}, 32'h5C);
        checkOutput("db_event",    {31'd0, eventDbErr}, 32'd1);
        checkOutput("db_sticky",   {31'd0, dbErrSticky}, 32'd1);
        checkOutput("db_sb_clean", {31'd0, sbErrSticky}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("db_clr_event",  {31'd0, eventDbErr}, 32'd0);
        checkOutput("db_clr_sticky", {31'd0, dbErrSticky}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("db_errclr", {31'd0, dbErrSticky}, 32'd0);

        // Single-bit error captured on the same edge as errClr: the set must win.
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sb_set_wins", {31'd0, sbErrSticky}, 32'd1);
        checkOutput("sb_event_db", {31'd0, eventDbErr}, 32'd0);
        checkOutput("sb_db_clean", {31'd0, dbErrSticky}, 32'd0);
        checkOutput("sb_cnt",      {16'd0, eventCnt}, 32'd7);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Fill to the watermark without clearing, then reset while in POP.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("wm_not_yet", {31'd0, wMarkSticky}, 32'd0);
        idle(1);
        checkOutput("wm_sticky", {31'd0, wMarkSticky}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("wm_set_wins", {31'd0, wMarkSticky}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wm_pop", {31'd0, fifoRdEn}, 32'd1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checkOutput("midrst_rd_en",  {31'd0, fifoRdEn}, 32'd0);
        checkOutput("midrst_valid",  {31'd0, intValid}, 32'd0);
        checkOutput("midrst_status", {24'd0, intStatus}, 32'd0);
        checkOutput("midrst_irq",    {31'd0, irq}, 32'd0);
        checkOutput("midrst_cnt",    {16'd0, eventCnt}, 32'd0);
        checkOutput("midrst_wm",     {31'd0, wMarkSticky}, 32'd0);
        idle(1);
        checkOutput("postrst_rd_en", {31'd0, fifoRdEn}, 32'd0);

        // Saturation of the 2-bit counter instance.
        serviceEvent(8'h01);
        serviceEvent(8'h02);
        checkOutput("sat_cnt2_two", {30'd0, cnt2}, 32'd2);
        serviceEvent(8'h03);
        serviceEvent(8'h04);
        serviceEvent(8'h05);
        checkOutput("sat_cnt2_hold", {30'd0, cnt2}, 32'd3);
        checkOutput("sat_cnt16",     {16'd0, eventCnt}, 32'd5);
        checkOutput("no_underflow",  {31'd0, underflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
